// File: rtl/mux_pkg.sv
// Shared encodings and helpers for the mux_arb_reg operand selector.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_reg_if.sv
// Channel and output handshake bundle for mux_arb_reg.
// out_par exists only when MUX_PARITY_EN is defined.
interface mux_arb_reg_if
  import mux_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32
);
  localparam int SW = idx_w(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_PARITY_EN
  logic           out_par;
`endif

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
`ifdef MUX_PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
`ifdef MUX_PARITY_EN
    , output out_par
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past ptr
// and wraps, first requester wins.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 2,
  localparam int SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);

  int   c;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (enable && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N:1 operand selector, fixed or round-robin grant.
// Optional out_par register enabled by MUX_PARITY_EN.
module mux_arb_reg
  import mux_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int W  = 32,
  localparam int SW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  mux_arb_reg_if.slave  bus
);

  logic [N-1:0]  req;
  logic [N-1:0]  fix_grant;
  logic [N-1:0]  rr_grant;
  logic [N-1:0]  grant;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] gidx;
  logic [W-1:0]  word;
  logic          load_en;
  logic          xfer;

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;
`ifdef MUX_PARITY_EN
  logic          out_par_q,   out_par_d;
`endif

  assign req = bus.in_valid;

  rr_arbiter #(.N(N)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .enable (1'b1),
    .grant  (rr_grant),
    .idx    (rr_idx)
  );

  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < N; i++)
      fix_grant[i] = (int'(sel) == i) && req[i];
  end

  // load_en uses the registered out_valid only, so no comb loop
  always_comb begin
    load_en = !out_valid_q || bus.out_ready;
    grant   = (mode == MODE_RR) ? rr_grant : fix_grant;
    gidx    = (mode == MODE_RR) ? rr_idx : sel;
    bus.in_ready = reset ? '0 : (grant & {N{load_en}});
    xfer    = |(bus.in_ready & bus.in_valid);
    word    = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) word = bus.in_data[i*W +: W];
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef MUX_PARITY_EN
    out_par_d   = out_par_q;
`endif
    if (xfer) begin
      out_data_d  = word;
      out_chan_d  = gidx;
      out_valid_d = 1'b1;
`ifdef MUX_PARITY_EN
      out_par_d   = ^word;
`endif
      if (mode == MODE_RR) ptr_d = rr_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(N-1);
`ifdef MUX_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
`ifdef MUX_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
`ifdef MUX_PARITY_EN
  assign bus.out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg (N=4 main, N=3 for out-of-range sel).
// Parity checks run when MUX_PARITY_EN is defined.
module tb_mux_arb_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode, mode3;
  logic [1:0] sel, sel3;
  int         n_cmp = 0;
  int         n_err = 0;

  mux_arb_reg_if #(.N(4), .W(32)) bus ();
  mux_arb_reg_if #(.N(3), .W(32)) b3 ();

  mux_arb_reg #(.N(4), .W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus.slave)
  );

  mux_arb_reg #(.N(3), .W(32)) dut3 (
    .clk   (clk),
    .reset (reset),
    .mode  (mode3),
    .sel   (sel3),
    .bus   (b3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    mode          = 1'b1;
    sel           = 2'd0;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      bus.in_data[i*32 +: 32] = 32'h1000_0000 + i;
    mode3         = 1'b0;
    sel3          = 2'd3;
    b3.in_valid   = 3'b111;
    b3.out_ready  = 1'b1;
    for (int i = 0; i < 3; i++)
      b3.in_data[i*32 +: 32] = 32'hA000_0000 + i;

    // reset with all channels requesting
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_data", 64'(bus.out_data), 64'h0);
    chk("rst_chan", 64'(bus.out_chan), 64'h0);
`ifdef MUX_PARITY_EN
    chk("rst_par", 64'(bus.out_par), 64'h0);
`endif
    reset = 1'b0;
    #1;
    chk("rr_first_ready", 64'(bus.in_ready), 64'h1);

    // round-robin fairness, full throughput
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_chan%0d", k), 64'(bus.out_chan), 64'(k % 4));
      chk($sformatf("rr_valid%0d", k), 64'(bus.out_valid), 64'h1);
      chk($sformatf("rr_data%0d", k), 64'(bus.out_data),
          64'(32'h1000_0000 + (k % 4)));
    end

    // backpressure holds the word and blocks all channels
    bus.out_ready = 1'b0;
    #1;
    chk("bp_ready0", 64'(bus.in_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_data%0d", k), 64'(bus.out_data), 64'h1000_0003);
      chk($sformatf("bp_valid%0d", k), 64'(bus.out_valid), 64'h1);
      chk($sformatf("bp_ready%0d", k), 64'(bus.in_ready), 64'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk("bp_reload_chan", 64'(bus.out_chan), 64'h0);
    chk("bp_reload_data", 64'(bus.out_data), 64'h1000_0000);
    chk("bp_reload_valid", 64'(bus.out_valid), 64'h1);

    // fixed select, channel 2
    mode = 1'b0;
    sel  = 2'd2;
    bus.in_valid = 4'b0100;
    bus.in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("fix_ready", 64'(bus.in_ready), 64'h4);
    tick();
    chk("fix_data", 64'(bus.out_data), 64'hDEAD_BEEF);
    chk("fix_chan", 64'(bus.out_chan), 64'h2);
    chk("fix_valid", 64'(bus.out_valid), 64'h1);
    bus.in_valid = 4'b0000;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'h0);
    chk("drain_hold", 64'(bus.out_data), 64'hDEAD_BEEF);

    // sparse: ptr still 0 after fixed transfer, move it to 1
    mode = 1'b1;
    bus.in_valid = 4'b0010;
    #1;
    chk("sp_ready1", 64'(bus.in_ready), 64'h2);
    tick();
    chk("sp_chan1", 64'(bus.out_chan), 64'h1);
    bus.in_valid = 4'b1001;
    #1;
    chk("sp_ready3", 64'(bus.in_ready), 64'h8);
    tick();
    chk("sp_chan3", 64'(bus.out_chan), 64'h3);
    #1;
    chk("sp_ready0", 64'(bus.in_ready), 64'h1);
    tick();
    chk("sp_chan0", 64'(bus.out_chan), 64'h0);
    chk("sp_data0", 64'(bus.out_data), 64'h1000_0000);

    // parity words, then reset while holding
    bus.in_valid = 4'b0001;
    bus.in_data[0 +: 32] = 32'h0000_0007;
    tick();
    chk("par7_data", 64'(bus.out_data), 64'h7);
`ifdef MUX_PARITY_EN
    chk("par7_par", 64'(bus.out_par), 64'h1);
`endif
    bus.in_data[0 +: 32] = 32'h0000_0003;
    tick();
    chk("par3_data", 64'(bus.out_data), 64'h3);
`ifdef MUX_PARITY_EN
    chk("par3_par", 64'(bus.out_par), 64'h0);
`endif
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0000;
    tick();
    chk("hold_valid", 64'(bus.out_valid), 64'h1);
    reset = 1'b1;
    tick();
    chk("midrst_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_data", 64'(bus.out_data), 64'h0);
`ifdef MUX_PARITY_EN
    chk("midrst_par", 64'(bus.out_par), 64'h0);
`endif
    reset = 1'b0;
    bus.out_ready = 1'b1;

    // N=3: sel=3 is out of range, no grant
    #1;
    chk("n3_oor_ready", 64'(b3.in_ready), 64'h0);
    tick();
    chk("n3_oor_valid", 64'(b3.out_valid), 64'h0);
    sel3 = 2'd1;
    #1;
    chk("n3_sel1_ready", 64'(b3.in_ready), 64'h2);
    tick();
    chk("n3_sel1_data", 64'(b3.out_data), 64'hA000_0001);
    chk("n3_sel1_chan", 64'(b3.out_chan), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N-channel, W-bit operand selector for the signed arithmetic datapath, generalising the 2:1 operand mux. Input channels use valid/ready handshakes. A grant is chosen by fixed select or round-robin arbitration. The chosen word is captured into a single output register with its own valid/ready handshake. The block sits ahead of the subtractor operand ports so that several producers can share one arithmetic unit at one word per cycle.

## Interface
- N, 2, number of input channels (N ≥ 2)
- W, 32, data width in bits (W ≥ 1)
- SW, $clog2(N), select/channel-index width (derived, not overridden)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel data valid
- in_ready  output  N  per-channel accept; at most one bit high per cycle
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SW  channel index used when mode = 0
- out_data  output  W  registered selected word
- out_chan  output  SW  index of the channel that supplied out_data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data
- out_par  output  1  even parity of out_data (only with MUX_PARITY_EN)

## Operation
- The clock is clk. Reset is synchronous and active-high, named reset.
- load_en = !out_valid | out_ready.
- Request vector req = in_valid.
- mode = 0: grant = one-hot(sel) & req. If sel ≥ N, there is no grant.
- mode = 1: round-robin over req. The search starts at (ptr+1) mod N and wraps at N-1→0. The first requesting channel wins.
- in_ready[i] = grant[i] & load_en. The signal is combinational from in_valid, mode, sel, ptr and out_ready.
- Transfer on channel i: in_valid[i] & in_ready[i]. On a transfer:
  - out_data ← channel word.
  - out_chan ← i.
  - out_valid ← 1.
- If out_ready & out_valid holds with no new transfer, out_valid ← 0. out_data and out_chan hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and out_valid stays 1. This gives full throughput of one word per cycle.
- If out_valid = 1 and out_ready = 0, all in_ready are 0 and the output register holds.
- ptr updates only on a transfer in mode 1: ptr ← granted index. A mode-0 transfer leaves ptr unchanged.
- A mode or sel change takes effect in the same cycle. No state is flushed.
- Arithmetic: pure selection. No width change and no sign handling; data bits pass unaltered.

## Timing
- Latency is 1 cycle from an input transfer to out_valid/out_data.
- Reset values:
  - out_valid = 0.
  - out_data = 0.
  - out_chan = 0.
  - ptr = N-1, so the first round-robin grant goes to channel 0.
  - out_par = 0.
- In the reset cycle, in_ready is forced to all-zero.
- Reset mid-operation: a held word is discarded without being delivered, and out_valid = 0 on the next cycle.
- in_ready must not depend on out_valid through a combinational loop. out_valid is a register.
- Fairness: in mode 1 with all N channels requesting continuously and out_ready = 1, each channel is granted once every N cycles.

## Configuration
- MUX_PARITY_EN defined:
  - The out_par port exists.
  - out_par is registered alongside out_data and equals ^out_data for every loaded word.
  - It resets to 0.
- MUX_PARITY_EN undefined: the out_par port and its register are absent. All other behaviour is identical.

## Structure
- Shared package mux_pkg holds:
  - the mode encodings MODE_FIXED = 1'b0 and MODE_RR = 1'b1;
  - the index-width helper function used to derive SW.
- Sub-module rr_arbiter, parametrised by N, contains:
  - inputs req, ptr and enable;
  - output one-hot grant plus the encoded index;
  - purely combinational logic.
- Top level contains the fixed/round-robin grant select, the ptr register, the output register and the handshake logic.

## Test plan
- Reset: assert reset with in_valid = all-ones → out_valid = 0, out_data = 0, in_ready = 0. After release, the first mode-1 grant goes to channel 0.
- Fixed select, N = 4, W = 32: mode = 0, sel = 2, channel 2 = 0xDEADBEEF valid, out_ready = 1 → next cycle out_data = 0xDEADBEEF, out_chan = 2. Other channels see in_ready = 0. sel = 5 with N = 8 and only 5 channels valid is not applicable; with N = 4, sel is always in range, so cover sel ≥ N at N = 3 using sel = 3 → no grant.
- Round-robin: N = 4, all channels valid, out_ready = 1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Backpressure: out_valid = 1 with out_ready = 0 for 3 cycles → out_data stable and in_ready = 0. On releasing out_ready, the word drains and a new word loads on the same edge.
- Sparse requests: mode 1, ptr = 1, only channels 0 and 3 valid → channel 3 is granted, then channel 0 (wrap-around).
- MUX_PARITY_EN: load 0x00000007 → out_par = 1; load 0x00000003 → out_par = 0. Reset mid-hold → out_valid = 0 and out_par = 0 next cycle.
